// File: rtl/ifetch_buffer.sv
// Instruction-fetch front end: sequential word reads, with at most one read
// outstanding, feeding an addressed FIFO that drains to decode. Supports branch redirect and halt.
module ifetch_buffer #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic                       clock_in,
  input  logic                       reset_in,
  input  logic                       halt_in,
  input  logic                       redirect_in,
  input  logic [31:0]                redirect_addr_in,
  output logic                       mem_read_out,
  output logic [31:0]                mem_addr_out,
  input  logic                       mem_valid_in,
  input  logic [31:0]                mem_data_in,
  output logic                       ins_valid_out,
  input  logic                       ins_ready_in,
  output logic [31:0]                ins_data_out,
  output logic [31:0]                ins_addr_out,
  output logic [$clog2(DEPTH):0]     fill_level_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_inc;
  logic [31:0]   redir_pc;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop, has_data;
  logic [31:0]   buf_data [DEPTH];
  logic [31:0]   buf_addr [DEPTH];
  logic          unused_bits;

  assign unused_bits = ^redirect_addr_in[1:0];
  assign redir_pc    = {redirect_addr_in[31:2], 2'b00};
  assign pc_inc      = fetch_pc + 32'd4;

  assign mem_read_out  = (state != IDLE);
  assign has_data      = (count != '0);
  assign ins_valid_out = has_data && !redirect_in;
  assign ins_data_out  = has_data ? buf_data[rd_ptr] : '0;
  assign ins_addr_out  = has_data ? buf_addr[rd_ptr] : '0;
  assign fill_level_out = count;

  // Redirect wins over a returning word; that word belongs to the old stream.
  assign push = (state == REQ) && mem_valid_in && !redirect_in;
  assign pop  = ins_valid_out && ins_ready_in;
  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state        <= IDLE;
      fetch_pc     <= RESET_ADDR;
      mem_addr_out <= RESET_ADDR;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_in)
            fetch_pc <= redir_pc;
          else if (!halt_in && count < FULL) begin
            state        <= REQ;
            mem_addr_out <= fetch_pc;
          end
        end
        REQ: begin
          if (redirect_in) begin
            fetch_pc <= redir_pc;
            // A read still in flight must be absorbed before a new one is issued.
            state    <= mem_valid_in ? IDLE : DROP;
          end else if (mem_valid_in) begin
            fetch_pc <= pc_inc;
            if (!halt_in && count_next < FULL)
              mem_addr_out <= pc_inc;
            else
              state <= IDLE;
          end
        end
        DROP: begin
          if (redirect_in)  fetch_pc <= redir_pc;
          if (mem_valid_in) state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count_next;
    end
  end

  always_ff @(posedge clock_in) begin
    if (push) begin
      buf_data[wr_ptr] <= mem_data_in;
      buf_addr[wr_ptr] <= fetch_pc;
    end
  end
endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer: vector table for streaming/backpressure,
// hand sequences for slow memory, redirect-in-flight, halt and async reset.
module tb_ifetch_buffer;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clock_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        halt_in = 1'b0, redirect_in = 1'b0;
  logic [31:0] redirect_addr_in = '0;
  logic        mem_read_out;
  logic [31:0] mem_addr_out;
  logic        mem_valid_in = 1'b0;
  logic [31:0] mem_data_in;
  logic        ins_valid_out;
  logic        ins_ready_in = 1'b0;
  logic [31:0] ins_data_out, ins_addr_out;
  logic [2:0]  fill_level_out;

  int tests = 0;
  int fails = 0;

  ifetch_buffer #(.DEPTH(4), .RESET_ADDR(32'h0)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .halt_in(halt_in),
    .redirect_in(redirect_in), .redirect_addr_in(redirect_addr_in),
    .mem_read_out(mem_read_out), .mem_addr_out(mem_addr_out),
    .mem_valid_in(mem_valid_in), .mem_data_in(mem_data_in),
    .ins_valid_out(ins_valid_out), .ins_ready_in(ins_ready_in),
    .ins_data_out(ins_data_out), .ins_addr_out(ins_addr_out),
    .fill_level_out(fill_level_out)
  );

  always #5 clock_in = ~clock_in;

  // Memory returns a word tagged by its address.
  assign mem_data_in = mem_addr_out ^ KEY;

  typedef struct {
    logic        rst, valid, ready;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_ia;
    logic [2:0]  exp_fill;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic valid, logic ready, logic rd,
                              logic [31:0] addr, logic iv, logic [31:0] ia, logic [2:0] fill);
    vec_t v;
    v.rst = rst; v.valid = valid; v.ready = ready;
    v.exp_read = rd; v.exp_addr = addr; v.exp_iv = iv; v.exp_ia = ia; v.exp_fill = fill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic rd, input logic [31:0] addr,
                         input logic iv, input logic [31:0] ia, input logic [2:0] fill);
    chk({tag, ".mem_read"}, {31'b0, mem_read_out}, {31'b0, rd});
    chk({tag, ".mem_addr"}, mem_addr_out, addr);
    chk({tag, ".ins_valid"}, {31'b0, ins_valid_out}, {31'b0, iv});
    chk({tag, ".ins_addr"}, ins_addr_out, ia);
    chk({tag, ".ins_data"}, ins_data_out, (fill != 0) ? (ia ^ KEY) : 32'h0);
    chk({tag, ".fill"}, {29'b0, fill_level_out}, {29'b0, fill});
  endtask

  task automatic drv(input logic halt, input logic redir, input logic [31:0] raddr,
                     input logic valid, input logic ready);
    @(posedge clock_in); #1;
    reset_in = 1'b0; halt_in = halt; redirect_in = redir; redirect_addr_in = raddr;
    mem_valid_in = valid; ins_ready_in = ready;
    #2;
  endtask

  initial begin
    // streaming at full rate, consumer always ready
    tbl.push_back(mk(1,0,0, 0,32'h00,0,32'h00,0));
    tbl.push_back(mk(0,1,1, 0,32'h00,0,32'h00,0));
    tbl.push_back(mk(0,1,1, 1,32'h00,0,32'h00,0));
    tbl.push_back(mk(0,1,1, 1,32'h04,1,32'h00,1));
    tbl.push_back(mk(0,1,1, 1,32'h08,1,32'h04,1));
    tbl.push_back(mk(0,1,1, 1,32'h0C,1,32'h08,1));
    tbl.push_back(mk(0,1,1, 1,32'h10,1,32'h0C,1));
    // backpressure: fill to 4, stop, then resume at 0x10
    tbl.push_back(mk(1,0,0, 0,32'h00,0,32'h00,0));
    tbl.push_back(mk(0,1,0, 0,32'h00,0,32'h00,0));
    tbl.push_back(mk(0,1,0, 1,32'h00,0,32'h00,0));
    tbl.push_back(mk(0,1,0, 1,32'h04,1,32'h00,1));
    tbl.push_back(mk(0,1,0, 1,32'h08,1,32'h00,2));
    tbl.push_back(mk(0,1,0, 1,32'h0C,1,32'h00,3));
    tbl.push_back(mk(0,1,0, 0,32'h0C,1,32'h00,4));
    tbl.push_back(mk(0,1,1, 0,32'h0C,1,32'h00,4));
    tbl.push_back(mk(0,1,1, 0,32'h0C,1,32'h04,3));
    tbl.push_back(mk(0,1,1, 1,32'h10,1,32'h08,2));
    tbl.push_back(mk(0,1,1, 1,32'h14,1,32'h0C,2));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clock_in); #1;
      reset_in = tbl[i].rst; halt_in = 1'b0; redirect_in = 1'b0;
      mem_valid_in = tbl[i].valid; ins_ready_in = tbl[i].ready;
      #2;
      chk_out($sformatf("vec%0d", i), tbl[i].exp_read, tbl[i].exp_addr,
              tbl[i].exp_iv, tbl[i].exp_ia, tbl[i].exp_fill);
    end

    // slow memory: address held for 3 cycles, single push on the valid cycle
    @(posedge clock_in); #1 reset_in = 1'b1;
    drv(0,0,0,0,0); chk_out("slow.c0", 0,32'h0,0,32'h0,0);
    drv(0,0,0,0,0); chk_out("slow.c1", 1,32'h0,0,32'h0,0);
    drv(0,0,0,0,0); chk_out("slow.c2", 1,32'h0,0,32'h0,0);
    drv(0,0,0,1,0); chk_out("slow.c3", 1,32'h0,0,32'h0,0);
    drv(0,0,0,1,0); chk_out("slow.c4", 1,32'h4,1,32'h0,1);

    // redirect to 0x103 while waiting at 0x8: old word dropped, restart at 0x100
    drv(0,1,32'h103,0,0);
    chk("redir.iv_forced", {31'b0, ins_valid_out}, 32'h0);
    chk("redir.addr_held", mem_addr_out, 32'h8);
    drv(0,0,0,0,0); chk_out("drop.wait", 1,32'h8,0,32'h0,0);
    drv(0,0,0,1,0); chk_out("drop.ret", 1,32'h8,0,32'h0,0);
    drv(0,0,0,0,0); chk_out("drop.idle", 0,32'h8,0,32'h0,0);
    drv(0,0,0,1,0); chk_out("redir.req", 1,32'h100,0,32'h0,0);

    // halt with a read outstanding: word lands, no new read until halt drops
    drv(1,0,0,0,0); chk_out("halt.c0", 1,32'h104,1,32'h100,1);
    drv(1,0,0,1,0); chk_out("halt.c1", 1,32'h104,1,32'h100,1);
    drv(1,0,0,0,0); chk_out("halt.c2", 0,32'h104,1,32'h100,2);
    drv(0,0,0,0,0); chk_out("halt.c3", 0,32'h104,1,32'h100,2);
    drv(0,0,0,0,0); chk_out("halt.c4", 1,32'h108,1,32'h100,2);

    // asynchronous reset mid-request with two entries buffered
    #2 reset_in = 1'b1;
    #1 chk_out("arst.now", 0,32'h0,0,32'h0,0);
    @(posedge clock_in); #1 mem_valid_in = 1'b1;
    #2 chk_out("arst.hold", 0,32'h0,0,32'h0,0);
    drv(0,0,0,1,1); chk_out("arst.c0", 0,32'h0,0,32'h0,0);
    drv(0,0,0,0,1); chk_out("arst.c1", 1,32'h0,0,32'h0,0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
